// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

    // Arbiter FSM: waiting for a request, or locked onto one requester's packet.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // The beat counter must be able to hold the value MAX_BEATS itself.
    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: first requester at or after last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; onehot is all-zero when no request is present.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk NUM_REQ positions starting one past the previous winner.
    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                index        = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter of NUM_REQ AXI-Stream sources onto one UART TX stream.
// Latency: one IDLE arbitration cycle per grant, then data passes combinationally.
// Backpressure: downstream tready is routed only to the granted source; others see 0.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BEATS  = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] slv_axis_tdata_i,
    input  logic [NUM_REQ-1:0]            slv_axis_tvalid_i,
    input  logic [NUM_REQ-1:0]            slv_axis_tlast_i,
    output logic [NUM_REQ-1:0]            slv_axis_tready_o,
    output logic [DATA_WIDTH-1:0]         mst_axis_tdata_o,
    output logic                          mst_axis_tvalid_o,
    output logic                          mst_axis_tlast_o,
    input  logic                          mst_axis_tready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          pkt_trunc_o
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam int               CNT_W     = beat_cnt_width(MAX_BEATS);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

    arb_state_t               state_q, state_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic                     pkt_trunc_q, pkt_trunc_d;

    logic [NUM_REQ-1:0]       pick_onehot;
    logic [IDX_W-1:0]         pick_idx;

    logic [DATA_WIDTH-1:0]    sel_dat;
    logic                     sel_vld;
    logic                     sel_last;
    logic                     in_xfer;
    logic                     beat_acc;
    logic                     at_limit;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (slv_axis_tvalid_i),
        .last   (last_grant_q),
        .onehot (pick_onehot),
        .index  (pick_idx)
    );

    // One-hot AND-OR mux of the granted source; grant_q is zero in IDLE so this yields zero there.
    always_comb begin
        sel_dat  = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_dat  = sel_dat | ({DATA_WIDTH{grant_q[k]}} & slv_axis_tdata_i[k*DATA_WIDTH +: DATA_WIDTH]);
            sel_vld  = sel_vld | (grant_q[k] & slv_axis_tvalid_i[k]);
            sel_last = sel_last | (grant_q[k] & slv_axis_tlast_i[k]);
        end
    end

    // Stream outputs are forced to zero outside XFER regardless of grant contents.
    always_comb begin
        in_xfer           = (state_q == XFER);
        mst_axis_tdata_o  = in_xfer ? sel_dat : '0;
        mst_axis_tvalid_o = in_xfer & sel_vld;
        mst_axis_tlast_o  = in_xfer & sel_last;
        slv_axis_tready_o = in_xfer ? (grant_q & {NUM_REQ{mst_axis_tready_i}}) : '0;
        beat_acc          = mst_axis_tvalid_o & mst_axis_tready_i;
        at_limit          = (beat_cnt_q == CNT_LIMIT);
    end

    // Next-state: grant in IDLE, release on tlast (normal) or on the MAX_BEATS-th beat (truncated).
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_trunc_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|slv_axis_tvalid_i) begin
                    state_d      = XFER;
                    grant_d      = pick_onehot;
                    last_grant_d = pick_idx;
                    beat_cnt_d   = '0;
                end
            end
            XFER: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (sel_last) begin
                        // tlast wins over the limit: a packet ending exactly at MAX_BEATS is not truncated.
                        state_d = IDLE;
                        grant_d = '0;
                    end else if (at_limit) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        pkt_trunc_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset points last_grant at the top index so requester 0 is searched first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            beat_cnt_q   <= '0;
            pkt_trunc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_trunc_q  <= pkt_trunc_d;
        end
    end

    assign busy_o      = (state_q == XFER);
    assign grant_o     = grant_q;
    assign pkt_trunc_o = pkt_trunc_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART payload width per beat.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of AXI-Stream requesters (range 2..16).
REQ-003 SHALL have parameter MAX_BEATS, default 256, maximum beats per granted packet before forced release (range >=1).
REQ-004 SHALL have clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have slv_axis_tdata_i  input  NUM_REQ*DATA_WIDTH  requester data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have slv_axis_tvalid_i  input  NUM_REQ  per-requester valid.
REQ-008 SHALL have slv_axis_tlast_i  input  NUM_REQ  per-requester end of packet.
REQ-009 SHALL have slv_axis_tready_o  output  NUM_REQ  per-requester ready.
REQ-010 SHALL have mst_axis_tdata_o  output  DATA_WIDTH  data to the UART transmitter.
REQ-011 SHALL have mst_axis_tvalid_o  output  1  valid to the UART transmitter.
REQ-012 SHALL have mst_axis_tlast_o  output  1  last beat of granted packet.
REQ-013 SHALL have mst_axis_tready_i  input  1  ready from the UART transmitter.
REQ-014 SHALL have grant_o  output  NUM_REQ  one-hot current grant; all-zero when idle.
REQ-015 SHALL have busy_o  output  1  high while a packet is granted.
REQ-016 SHALL have pkt_trunc_o  output  1  one-cycle pulse when a grant is force-released by MAX_BEATS.

Function
REQ-017 SHALL implement FSM states IDLE and XFER.
REQ-018 In IDLE, if any slv_axis_tvalid_i bit is high, SHALL register a grant to the round-robin winner and enter XFER on the next edge; otherwise it SHALL stay in IDLE.
REQ-019 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ and wrap; last_grant SHALL update only when a grant is issued.
REQ-020 In XFER, mst_axis_tdata_o, mst_axis_tvalid_o and mst_axis_tlast_o SHALL combinationally follow the granted requester's inputs.
REQ-021 In XFER, slv_axis_tready_o[granted] SHALL equal mst_axis_tready_i; all other ready bits SHALL be 0.
REQ-022 In IDLE, all slv_axis_tready_o bits, mst_axis_tvalid_o and mst_axis_tlast_o SHALL be 0, and mst_axis_tdata_o SHALL be 0.
REQ-023 A beat SHALL count as accepted when mst_axis_tvalid_o and mst_axis_tready_i are both high.
REQ-024 The beat counter SHALL be $clog2(MAX_BEATS+1) bits wide, clear on grant and increment on every accepted beat.
REQ-025 An accepted beat with tlast high SHALL return the FSM to IDLE on the next edge.
REQ-026 An accepted beat that brings the count to MAX_BEATS without tlast SHALL return the FSM to IDLE and pulse pkt_trunc_o for exactly one cycle.
REQ-027 If tlast and the MAX_BEATS limit occur on the same beat, the release SHALL be normal and pkt_trunc_o SHALL stay 0.
REQ-028 Mid-packet tvalid deassertion by the granted requester SHALL NOT release the grant; the lock SHALL hold indefinitely.
REQ-029 Requests from non-granted requesters during XFER SHALL be ignored until the FSM returns to IDLE.
REQ-030 Packet-to-packet overhead SHALL be exactly one idle cycle, the IDLE arbitration cycle.
REQ-031 busy_o SHALL be high iff the state is XFER, and grant_o SHALL be the registered one-hot grant.

Reset
REQ-032 When rst_i is high at a clock edge, the block SHALL enter IDLE, clear grant_o, busy_o, pkt_trunc_o and the beat counter, and set last_grant to NUM_REQ-1 so requester 0 has first priority.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no truncation pulse, and all outputs SHALL read as the IDLE values from the following cycle.

Structure
REQ-034 Package uart_arb_pkg SHALL hold the state typedef arb_state_t {IDLE, XFER} and a function returning the beat-counter width.
REQ-035 The round-robin winner search SHALL be a combinational sub-module rr_picker with inputs req, last and outputs onehot, index.

Verification
REQ-036 Reset release with NUM_REQ=4 and only requester 2 sending a 3-beat packet, tready=1 -> grant_o=4'b0100 one cycle later, 3 beats out in order, tlast on the third, busy_o low after it.
REQ-037 All 4 requesters continuously sending 1-beat packets -> grant order 0,1,2,3,0, each grant separated by one idle cycle.
REQ-038 Requester 1 granted with tready toggling 1010..., and requester 0 requesting mid-packet -> requester 1's packet completes uninterrupted and requester 0 is granted next.
REQ-039 MAX_BEATS=4 and a 6-beat packet -> release after beat 4, pkt_trunc_o pulses once, and the remaining beats continue as a new grant.
REQ-040 MAX_BEATS=4 and a 4-beat packet with tlast on beat 4 -> pkt_trunc_o stays 0.
REQ-041 rst_i asserted for one cycle during beat 2 of 5 -> following cycle: IDLE, all ready bits 0, grant_o=0, and next grant goes to requester 0 first.
